// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: load/store types, grant states
// and the access-size helper used by the range check.
package mem_arb_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_G_IF = 2'd1,
    GS_G_DM = 2'd2
  } grant_state_e;

  // Bytes touched by a DM access; unused encodings are treated as a full word.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] ltype,
                                             input logic [1:0] stype);
    logic [2:0] sz;
    if (we) begin
      case (stype)
        ST_SB:   sz = 3'd1;
        ST_SH:   sz = 3'd2;
        default: sz = 3'd4;
      endcase
    end else begin
      case (ltype)
        LT_LB, LT_LBU: sz = 3'd1;
        LT_LH, LT_LHU: sz = 3'd2;
        default:       sz = 3'd4;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the shared memory port: DM first, IF forced through after
// MAX_STREAK consecutive DM grants while IF waits.
//
//  state   | meaning
//  GS_IDLE | no access granted last cycle
//  GS_G_IF | last cycle served instruction fetch
//  GS_G_DM | last cycle served the MEM stage
module mem_arb_prio import mem_arb_pkg::*; #(
  parameter int MAX_STREAK = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req_i,
  input  logic         dm_req_i,
  output logic         grant_if_o,
  output logic         grant_dm_o,
  output grant_state_e last_grant_o
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0]   r_streak;
  grant_state_e r_state;
  logic         w_at_limit;

  assign w_at_limit   = if_req_i && (r_streak == STREAK_MAX);
  assign grant_dm_o   = !rst && dm_req_i && !w_at_limit;
  assign grant_if_o   = !rst && if_req_i && !grant_dm_o;
  assign last_grant_o = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= GS_IDLE;
      r_streak <= '0;
    end else begin
      if (grant_dm_o)      r_state <= GS_G_DM;
      else if (grant_if_o) r_state <= GS_G_IF;
      else                 r_state <= GS_IDLE;

      if (grant_dm_o && if_req_i)
        r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 4'd1;
      else
        r_streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM-stage accesses onto one byte-addressed data memory.
// Optional ARB_PERF_CNT_EN adds saturating conflict / forced-grant counters.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = 8,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  input  logic [2:0]        dm_ltype_i,
  input  logic [1:0]        dm_stype_i,
  output logic              dm_ack_o,
  output logic              dm_rvalid_o,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_err_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [2:0]        mem_ltype_o,
  output logic [1:0]        mem_stype_o,
  input  logic [31:0]       mem_rdata_i
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_conflict_o,
  output logic [15:0]       perf_forced_o
`endif
);

  logic         w_grant_if;
  logic         w_grant_dm;
  grant_state_e w_last_grant;
  logic [2:0]   w_size;
  logic [ADDR_W:0] w_end_addr;
  logic         w_range_err;
  logic         w_dm_go;
  logic         w_dm_load;
  logic [31:0]  r_if_rdata;
  logic [31:0]  r_dm_rdata;
  logic         r_dm_rvalid;

  mem_arb_prio #(.MAX_STREAK(MAX_STREAK)) u_prio (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .dm_req_i     (dm_req_i),
    .grant_if_o   (w_grant_if),
    .grant_dm_o   (w_grant_dm),
    .last_grant_o (w_last_grant)
  );

  // One extra address bit catches accesses running past the top of memory.
  assign w_size      = access_size(dm_we_i, dm_ltype_i, dm_stype_i);
  assign w_end_addr  = {1'b0, dm_addr_i} + (ADDR_W+1)'(w_size - 3'd1);
  assign w_range_err = w_end_addr[ADDR_W];
  assign w_dm_go     = w_grant_dm && !w_range_err;
  assign w_dm_load   = w_grant_dm && !dm_we_i;

  always_comb begin
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_ltype_o = '0;
    mem_stype_o = '0;
    if (w_grant_if) begin
      mem_rd_en_o = 1'b1;
      mem_addr_o  = if_addr_i;
      mem_ltype_o = LT_LW;
    end else if (w_dm_go) begin
      mem_rd_en_o = !dm_we_i;
      mem_wr_en_o = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_ltype_o = dm_ltype_i;
      mem_stype_o = dm_stype_i;
    end
  end

  assign if_ack_o = w_grant_if;
  assign dm_ack_o = w_grant_dm;
  assign dm_err_o = w_grant_dm && w_range_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
    end else begin
      r_dm_rvalid <= w_dm_load;
      if (w_grant_if) r_if_rdata <= mem_rdata_i;
      if (w_dm_load)  r_dm_rdata <= w_range_err ? 32'd0 : mem_rdata_i;
    end
  end

  // Gating with rst drops a read response that would land in a reset cycle.
  assign if_rvalid_o = !rst && (w_last_grant == GS_G_IF);
  assign dm_rvalid_o = !rst && r_dm_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_perf_conflict;
  logic [15:0] r_perf_forced;

  // IF can only win against a pending DM request when the streak limit forces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_conflict <= '0;
      r_perf_forced   <= '0;
    end else begin
      if (if_req_i && dm_req_i && !w_grant_if && (r_perf_conflict != 16'hFFFF))
        r_perf_conflict <= r_perf_conflict + 16'd1;
      if (w_grant_if && dm_req_i && (r_perf_forced != 16'hFFFF))
        r_perf_forced <= r_perf_forced + 16'd1;
    end
  end

  assign perf_conflict_o = r_perf_conflict;
  assign perf_forced_o   = r_perf_forced;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural byte memory and an
// independent reference copy used to predict read data and grants.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [7:0]  if_addr_i;
  logic        if_ack_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i, dm_we_i;
  logic [7:0]  dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [2:0]  dm_ltype_i;
  logic [1:0]  dm_stype_i;
  logic        dm_ack_o, dm_rvalid_o, dm_err_o;
  logic [31:0] dm_rdata_o;
  logic        mem_rd_en_o, mem_wr_en_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [2:0]  mem_ltype_o;
  logic [1:0]  mem_stype_o;
  logic [31:0] mem_rdata_i;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflict_o, perf_forced_o;
`endif

  mem_port_arbiter #(.ADDR_W(8), .MAX_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ltype_i(dm_ltype_i), .dm_stype_i(dm_stype_i),
    .dm_ack_o(dm_ack_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .dm_err_o(dm_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ltype_o(mem_ltype_o), .mem_stype_o(mem_stype_o),
    .mem_rdata_i(mem_rdata_i)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict_o(perf_conflict_o), .perf_forced_o(perf_forced_o)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural memory: async read with load type, sync write with store type.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ma1, ma2, ma3, rb0, rb1, rb2, rb3;
  assign ma1 = mem_addr_o + 8'd1;
  assign ma2 = mem_addr_o + 8'd2;
  assign ma3 = mem_addr_o + 8'd3;
  assign rb0 = mem[mem_addr_o];
  assign rb1 = mem[ma1];
  assign rb2 = mem[ma2];
  assign rb3 = mem[ma3];

  always_comb begin
    case (mem_ltype_o)
      3'b000:  mem_rdata_i = {{24{rb0[7]}}, rb0};
      3'b001:  mem_rdata_i = {24'd0, rb0};
      3'b010:  mem_rdata_i = {{16{rb1[7]}}, rb1, rb0};
      3'b011:  mem_rdata_i = {16'd0, rb1, rb0};
      default: mem_rdata_i = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en_o) begin
      mem[mem_addr_o] <= mem_wdata_o[7:0];
      if (mem_stype_o != 2'b00) mem[ma1] <= mem_wdata_o[15:8];
      if (mem_stype_o != 2'b00 && mem_stype_o != 2'b01) begin
        mem[ma2] <= mem_wdata_o[23:16];
        mem[ma3] <= mem_wdata_o[31:24];
      end
    end
  end

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  int          m_streak = 0;
  logic [1:0]  last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] lt);
    logic [7:0] a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    b0 = ref_mem[a]; b1 = ref_mem[a1]; b2 = ref_mem[a2]; b3 = ref_mem[a3];
    case (lt)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {24'd0, b0};
      3'b010:  return {{16{b1[7]}}, b1, b0};
      3'b011:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [31:0] wd, input int sz);
    for (int k = 0; k < sz; k++) begin
      logic [7:0] ak;
      ak = a + 8'(k);
      ref_mem[ak] = wd[8*k +: 8];
    end
  endtask

  // One clock cycle: drive at negedge, check last cycle's read data, then this cycle's grant.
  task automatic step(input logic rs, input logic ir, input logic [7:0] ia,
                      input logic dr, input logic we, input logic [7:0] da,
                      input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] st);
    logic exp_gdm, exp_gif, exp_err, exp_go;
    int   sz;
    @(negedge clk);
    rst = rs; if_req_i = ir; if_addr_i = ia;
    dm_req_i = dr; dm_we_i = we; dm_addr_i = da; dm_wdata_i = wd;
    dm_ltype_i = lt; dm_stype_i = st;
    #2;
    if (rs) begin
      if_q.delete();
      dm_q.delete();
    end
    if (if_q.size() > 0) begin
      chk("if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      chk("if_rdata", if_rdata_o, if_q.pop_front());
    end else chk("if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    if (dm_q.size() > 0) begin
      chk("dm_rvalid", {31'd0, dm_rvalid_o}, 32'd1);
      chk("dm_rdata", dm_rdata_o, dm_q.pop_front());
    end else chk("dm_rvalid", {31'd0, dm_rvalid_o}, 32'd0);

    if (we) sz = (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : 4;
    else    sz = (lt <= 3'b001) ? 1 : (lt <= 3'b011) ? 2 : 4;
    exp_gdm = !rs && dr && !(ir && m_streak == 3);
    exp_gif = !rs && ir && !exp_gdm;
    exp_err = exp_gdm && (int'(da) + sz - 1 > 255);
    exp_go  = exp_gdm && !exp_err;

    chk("if_ack", {31'd0, if_ack_o}, {31'd0, exp_gif});
    chk("dm_ack", {31'd0, dm_ack_o}, {31'd0, exp_gdm});
    chk("dm_err", {31'd0, dm_err_o}, {31'd0, exp_err});
    chk("mem_rd_en", {31'd0, mem_rd_en_o}, {31'd0, exp_gif || (exp_go && !we)});
    chk("mem_wr_en", {31'd0, mem_wr_en_o}, {31'd0, exp_go && we});
    if (exp_gif) begin
      chk("mem_addr_if", {24'd0, mem_addr_o}, {24'd0, ia});
      chk("mem_ltype_if", {29'd0, mem_ltype_o}, 32'd4);
    end else if (exp_go) begin
      chk("mem_addr_dm", {24'd0, mem_addr_o}, {24'd0, da});
      if (we) chk("mem_wdata", mem_wdata_o, wd);
    end else begin
      chk("mem_addr_idle", {24'd0, mem_addr_o}, 32'd0);
      chk("mem_wdata_idle", mem_wdata_o, 32'd0);
    end

    if (exp_gif) if_q.push_back(ref_load(ia, 3'b100));
    if (exp_gdm && !we) dm_q.push_back(exp_err ? 32'd0 : ref_load(da, lt));
    if (exp_go && we) ref_store(da, wd, sz);

    if (rs) m_streak = 0;
    else if (exp_gdm && ir) m_streak = (m_streak == 3) ? 3 : m_streak + 1;
    else m_streak = 0;
    last_g = {if_ack_o, dm_ack_o};
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 3'b000, 2'b00);
  endtask

  logic [1:0] t4_seq [6];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'((i * 37 + 11) & 255);
      ref_mem[i] = 8'((i * 37 + 11) & 255);
    end
    mem[8'h10] = 8'h93; mem[8'h11] = 8'h00; mem[8'h12] = 8'hA0; mem[8'h13] = 8'h00;
    ref_mem[8'h10] = 8'h93; ref_mem[8'h11] = 8'h00; ref_mem[8'h12] = 8'hA0; ref_mem[8'h13] = 8'h00;
    t4_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; dm_ltype_i = '0; dm_stype_i = '0;

    // reset with both requests pending
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h30, 32'h12345678, 3'b100, 2'b10);
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h30, 32'h12345678, 3'b100, 2'b10);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    idle();

    // IF only
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'd0, 3'b000, 2'b00);
    idle();
    chk("if_rdata_held", if_rdata_o, 32'h00A00093);

    // SW then LB, plus halfword variants
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 3'b000, 2'b10);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h23, 32'd0, 3'b000, 2'b00);
    idle();
    chk("lb_signext", dm_rdata_o, 32'hFFFFFFDE);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 32'd0, 3'b011, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 32'd0, 3'b010, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 32'h0000A5C3, 3'b000, 2'b01);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 32'd0, 3'b100, 2'b00);
    idle();

    // streak limit: DM,DM,DM,IF,DM,DM
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h40, 32'd0, 3'b100, 2'b00);
      chk("t4_grant", {30'd0, last_g}, {30'd0, t4_seq[i]});
    end
    idle();

    // range check at top of memory
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFE, 32'd0, 3'b100, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 32'h00000055, 3'b000, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 32'd0, 3'b001, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFD, 32'hCAFEF00D, 3'b000, 2'b10);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFC, 32'd0, 3'b100, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 32'd0, 3'b010, 2'b00);
    idle();

    // reset right after a load ack, with streak built up
    step(1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 8'h40, 32'd0, 3'b100, 2'b00);
    step(1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 8'h44, 32'd0, 3'b100, 2'b00);
    step(1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 8'h48, 32'd0, 3'b100, 2'b00);
    step(1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 8'h48, 32'h11111111, 3'b100, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 8'h48, 32'd0, 3'b100, 2'b00);
      chk("t6_grant", {30'd0, last_g}, (i == 3) ? 32'd2 : 32'd1);
    end
    idle();

    // random mix
    for (int i = 0; i < 120; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom(),
           3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)));
    end
    idle();
    idle();
    chk("if_q_drained", if_q.size(), 32'd0);
    chk("dm_q_drained", dm_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
